// File: rtl/xts_tweak_rewind.sv
// XTS tweak rewind: applies `steps` GF(2^128) halvings (or doublings when XTS_TWEAK_FWD_EN
// is defined and dir=1) to a loaded tweak, one step per clock.
// Latency: out_valid rises steps+1 cycles after start is sampled. Result is held in DONE until out_ready.
// Ports: clk/rst (async active-high), load/tweak_in capture a tweak and abort any operation,
//        start/steps (and dir under XTS_TWEAK_FWD_EN) launch a run, busy/out_valid/out_ready/tweak_out
//        report and hand off the result. tweak_out is the tweak register itself.
module xts_tweak_rewind (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] tweak_in,
    input  logic         start,
    input  logic [7:0]   steps,
`ifdef XTS_TWEAK_FWD_EN
    input  logic         dir,
`endif
    output logic         busy,
    output logic [127:0] tweak_out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REWIND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] tweak_q, tweak_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] step_val;

    // The bus carries tweak byte 0 in the top byte, while the polynomial has
    // bit 0 in the LSB of byte 0. Reversing byte order turns the bus into a
    // plain 128-bit polynomial integer (and back again).
    function automatic logic [127:0] byte_swap(input logic [127:0] v);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            r[8*b +: 8] = v[120-8*b +: 8];
        end
        return r;
    endfunction

    // Inverse of the tweak doubling: undo the 0x87 reduction when the
    // shifted-out bit was set, and restore the carried-out top bit.
    function automatic logic [127:0] gf_half(input logic [127:0] p);
        logic [127:0] r;
        if (p[0]) begin
            r = ((p ^ 128'h87) >> 1) | {1'b1, 127'd0};
        end else begin
            r = p >> 1;
        end
        return r;
    endfunction

`ifdef XTS_TWEAK_FWD_EN
    logic dir_q, dir_d;

    function automatic logic [127:0] gf_dbl(input logic [127:0] p);
        logic [127:0] r;
        r = p << 1;
        if (p[127]) begin
            r = r ^ 128'h87;
        end
        return r;
    endfunction

    always_comb begin
        if (dir_q) begin
            step_val = byte_swap(gf_dbl(byte_swap(tweak_q)));
        end else begin
            step_val = byte_swap(gf_half(byte_swap(tweak_q)));
        end
    end
`else
    always_comb begin
        step_val = byte_swap(gf_half(byte_swap(tweak_q)));
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tweak_q <= 128'd0;
            cnt_q   <= 8'd0;
`ifdef XTS_TWEAK_FWD_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            tweak_q <= tweak_d;
            cnt_q   <= cnt_d;
`ifdef XTS_TWEAK_FWD_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state and datapath update; load overrides everything else.
    always_comb begin
        state_d = state_q;
        tweak_d = tweak_q;
        cnt_d   = cnt_q;
`ifdef XTS_TWEAK_FWD_EN
        dir_d   = dir_q;
`endif
        if (load) begin
            tweak_d = tweak_in;
            cnt_d   = 8'd0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d   = steps;
`ifdef XTS_TWEAK_FWD_EN
                        dir_d   = dir;
`endif
                        state_d = (steps == 8'd0) ? DONE : REWIND;
                    end
                end
                REWIND: begin
                    tweak_d = step_val;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs, all derived from registers
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        tweak_out = tweak_q;
    end

endmodule

// File: tb/tb_xts_tweak_rewind.sv
module tb_xts_tweak_rewind;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] tweak_in;
    logic         start;
    logic [7:0]   steps_i;
    logic         busy;
    logic [127:0] tweak_out;
    logic         out_valid;
    logic         out_ready;
`ifdef XTS_TWEAK_FWD_EN
    logic         dir;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xts_tweak_rewind dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .tweak_in  (tweak_in),
        .start     (start),
        .steps     (steps_i),
`ifdef XTS_TWEAK_FWD_EN
        .dir       (dir),
`endif
        .busy      (busy),
        .tweak_out (tweak_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [127:0] tin;
        logic [7:0]   steps;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Optionally load tin, start a run of `st` steps, check latency, result,
    // back-pressure hold, and the handshake back to IDLE.
    task automatic run_vec(input string name, input bit do_load, input logic [127:0] tin,
                           input logic [7:0] st, input logic [127:0] exp);
        int lat;
        logic [127:0] res;
        if (do_load) begin
            load = 1'b1;
            tweak_in = tin;
            tick();
            load = 1'b0;
            chk({name, "_load"}, tweak_out, tin);
        end
        start = 1'b1;
        steps_i = st;
        tick();
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'(int'(st) + 1));
        chk({name, "_result"}, tweak_out, exp);
        chk({name, "_busy"}, 128'(busy), 128'd1);
        res = tweak_out;
        repeat (3) tick();
        chk({name, "_hold_val"}, tweak_out, res);
        chk({name, "_hold_vld"}, 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_ack_vld"}, 128'(out_valid), 128'd0);
        chk({name, "_ack_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] rnd;
        vecs[0] = '{128'h01000000_00000000_00000000_00000000, 8'd1,   128'h43000000_00000000_00000000_00000080};
        vecs[1] = '{128'h02000000_00000000_00000000_00000000, 8'd2,   128'h43000000_00000000_00000000_00000080};
        vecs[2] = '{128'h00010000_00000000_00000000_00000000, 8'd0,   128'h00010000_00000000_00000000_00000000};
        vecs[3] = '{128'h00010000_00000000_00000000_00000000, 8'd1,   128'h80000000_00000000_00000000_00000000};
        vecs[4] = '{128'h00010000_00000000_00000000_00000000, 8'd8,   128'h01000000_00000000_00000000_00000000};
        vecs[5] = '{128'h00000000_00000000_00000000_00000001, 8'd1,   128'h00000000_00000000_00000000_00008000};
        vecs[6] = '{128'h80000000_00000000_00000000_00000000, 8'd7,   128'h01000000_00000000_00000000_00000000};
        vecs[7] = '{128'h01000000_00000000_00000000_00000000, 8'd2,   128'h62000000_00000000_00000000_000000C0};
        vecs[8] = '{128'h00000000_00000000_00000000_00000000, 8'd255, 128'h00000000_00000000_00000000_00000000};

        rst = 1'b1; load = 1'b0; tweak_in = '0; start = 1'b0; steps_i = '0; out_ready = 1'b0;
`ifdef XTS_TWEAK_FWD_EN
        dir = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_vld", 128'(out_valid), 128'd0);
        chk("rst_tweak", tweak_out, 128'd0);
        rst = 1'b0;

        // First edge after reset release honours load (inside run_vec).
        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), 1'b1, vecs[i].tin, vecs[i].steps, vecs[i].exp);
        end

        // start ignored while rewinding and while in DONE
        load = 1'b1; tweak_in = 128'h00010000_00000000_00000000_00000000; tick(); load = 1'b0;
        start = 1'b1; steps_i = 8'd8; tick();
        start = 1'b0; tick();
        start = 1'b1; steps_i = 8'd0; tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ign_start_rewind_vld", 128'(out_valid), 128'd0);
        tick();
        chk("ign_start_rewind_done", 128'(out_valid), 128'd1);
        chk("ign_start_rewind_val", tweak_out, 128'h01000000_00000000_00000000_00000000);
        start = 1'b1; steps_i = 8'd3; repeat (2) tick(); start = 1'b0;
        chk("ign_start_done_vld", 128'(out_valid), 128'd1);
        chk("ign_start_done_val", tweak_out, 128'h01000000_00000000_00000000_00000000);

        // load together with handshake in DONE: load wins, result replaced
        load = 1'b1; out_ready = 1'b1; tweak_in = 128'h11223344_55667788_99AABBCC_DDEEFF00; tick();
        load = 1'b0; out_ready = 1'b0;
        chk("load_done_busy", 128'(busy), 128'd0);
        chk("load_done_val", tweak_out, 128'h11223344_55667788_99AABBCC_DDEEFF00);

        // load together with start in IDLE: load wins, no run begins
        load = 1'b1; start = 1'b1; steps_i = 8'd4; tweak_in = 128'h02000000_00000000_00000000_00000000; tick();
        load = 1'b0; start = 1'b0;
        chk("load_start_busy", 128'(busy), 128'd0);
        tick();
        chk("load_start_val", tweak_out, 128'h02000000_00000000_00000000_00000000);

        // abort with load at cycle 50 of a 200-step run
        start = 1'b1; steps_i = 8'd200; tick(); start = 1'b0;
        repeat (49) tick();
        chk("abort_busy_before", 128'(busy), 128'd1);
        load = 1'b1; tweak_in = {16{8'hAA}}; tick(); load = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_vld", 128'(out_valid), 128'd0);
        chk("abort_val", tweak_out, {16{8'hAA}});
        repeat (5) tick();
        chk("abort_vld_later", 128'(out_valid), 128'd0);
        chk("abort_val_later", tweak_out, {16{8'hAA}});

        // asynchronous reset in the middle of a rewind
        start = 1'b1; steps_i = 8'd100; tick(); start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_vld", 128'(out_valid), 128'd0);
        chk("arst_val", tweak_out, 128'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) tick();
        chk("arst_post_vld", 128'(out_valid), 128'd0);
        run_vec("post_rst", 1'b1, vecs[0].tin, vecs[0].steps, vecs[0].exp);

        // reset while in DONE discards the result
        load = 1'b1; tweak_in = vecs[0].tin; tick(); load = 1'b0;
        start = 1'b1; steps_i = 8'd0; tick(); start = 1'b0;
        chk("done_rst_pre", 128'(out_valid), 128'd1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("done_rst_vld", 128'(out_valid), 128'd0);
        chk("done_rst_val", tweak_out, 128'd0);

`ifdef XTS_TWEAK_FWD_EN
        dir = 1'b1;
        run_vec("fwd", 1'b1, 128'h43000000_00000000_00000000_00000080, 8'd2,
                128'h02000000_00000000_00000000_00000000);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] n;
            rnd = {$urandom, $urandom, $urandom, $urandom};
            n = 8'($urandom_range(1, 40));
            dir = 1'b1;
            load = 1'b1; tweak_in = rnd; tick(); load = 1'b0;
            start = 1'b1; steps_i = n; tick(); start = 1'b0;
            for (int c = 0; c < 300 && !out_valid; c++) tick();
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            dir = 1'b0;
            run_vec($sformatf("rtrip%0d", k), 1'b0, '0, n, rnd);
        end
`else
        rnd = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xts_tweak_rewind.md
XTS_TWEAK_REWIND -- requirements
Module: xts_tweak_rewind

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-002 load  input  1  Capture tweak_in into the tweak register; also aborts any operation in progress.
REQ-003 tweak_in  input  128  Starting tweak, in the codebase tweak byte layout (see REQ-010).
REQ-004 start  input  1  Begin a rewind of `steps` blocks; sampled only in IDLE.
REQ-005 steps  input  8  Number of GF(2^128) halvings to apply, 0..255.
REQ-006 busy  output  1  High whenever state is not IDLE.
REQ-007 tweak_out  output  128  Current tweak register contents.
REQ-008 out_valid  output  1  Result ready; high only in DONE.
REQ-009 out_ready  input  1  Consumer accepts the result.

Function
REQ-010 The 128-bit bus SHALL map tweak byte b to bits [127-8b:120-8b]; polynomial bit k of byte b is bus bit 120-8b+k; polynomial bit 0 is bus bit 120, and bit 127 is bus bit 7.
REQ-011 One halving SHALL compute T' = T>>1 when poly bit 0 = 0, else ((T ^ 0x87)>>1) | (1<<127), with 0x87 XORed into byte 0; this is the exact inverse of the codebase tweak doubling.
REQ-012 The FSM SHALL have exactly the states IDLE, REWIND and DONE.
REQ-013 In IDLE, start=1 and load=0: cnt <= steps; the next state is DONE if steps==0, else REWIND.
REQ-014 In REWIND, each clock edge: tweak_reg <= half(tweak_reg), cnt <= cnt-1; when cnt==1 on that edge, the next state is DONE.
REQ-015 Latency: out_valid SHALL rise steps+1 cycles after the cycle in which start is sampled (1 cycle for steps=0).
REQ-016 In DONE: out_valid=1 and tweak_out is held stable; when out_valid && out_ready, the next state is IDLE and out_valid drops on the following cycle.
REQ-017 Back-pressure: DONE SHALL persist indefinitely while out_ready=0, with tweak_out unchanged.
REQ-018 start SHALL be ignored in REWIND and DONE.
REQ-019 load SHALL take priority in every state: tweak_reg <= tweak_in, cnt <= 0, next state IDLE; this applies even when start or the handshake occurs in the same cycle.
REQ-020 tweak_out SHALL equal tweak_reg at all times (registered output, no combinational path from inputs).
REQ-021 The cnt width SHALL be 8 bits; steps=255 completes in 256 cycles with no wrap-around.

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, tweak_reg=0, cnt=0, busy=0, out_valid=0, tweak_out=0.
REQ-023 Reset asserted mid-REWIND or in DONE SHALL discard the operation; no partial result is presented after reset releases.
REQ-024 The first load or start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro XTS_TWEAK_FWD_EN: when defined, the block SHALL add input dir (1 bit), sampled with start; dir=1 selects GF doubling per step (T<<1, with 0x87 XORed into byte 0 on carry-out of poly bit 127) instead of halving, and dir=0 selects halving.
REQ-026 Without XTS_TWEAK_FWD_EN, no dir port SHALL exist and every step SHALL be a halving.

Verification
REQ-027 Load 128'h01000000000000000000000000000000, start steps=1 -> out_valid after 2 cycles, tweak_out=128'h43000000000000000000000000000080.
REQ-028 Load 128'h02000000000000000000000000000000, steps=2 -> out_valid after 3 cycles, tweak_out=128'h43000000000000000000000000000080; hold out_ready=0 for 5 cycles -> value stable and busy=1.
REQ-029 Load 128'h00010000000000000000000000000000, steps=0 -> out_valid next cycle with the value unchanged; steps=1 from the same load -> 128'h80000000000000000000000000000000 (cross-byte carry).
REQ-030 Start steps=200, assert load=128'hAA..AA (all bytes 0xAA) at cycle 50 -> IDLE next cycle, busy=0, tweak_out=128'hAA..AA, no out_valid; assert rst mid-REWIND -> all outputs 0 immediately.
REQ-031 XTS_TWEAK_FWD_EN: load 128'h43000000000000000000000000000080, dir=1, steps=2 -> tweak_out=128'h02000000000000000000000000000000; a random-value round trip (N forward then N back) returns the original value.
